// File: rtl/guess_game_ctrl_if.sv
// rtl/guess_game_ctrl_if.sv - button/switch inputs and LED/display outputs of the guessing game
`timescale 1ns/1ps
interface guess_game_ctrl_if;
  logic [3:0] btn;
  logic [3:0] sw;
  logic [3:0] led;
  logic [3:0] digit_val;
  logic       digit_blank;
  logic       chip_sel;

  modport master (
    output btn, sw,
    input  led, digit_val, digit_blank, chip_sel
  );

  modport slave (
    input  btn, sw,
    output led, digit_val, digit_blank, chip_sel
  );
endinterface

// File: rtl/guess_game_ctrl.sv
// rtl/guess_game_ctrl.sv - guessing game controller: debounce, LFSR secret, game FSM, display mux (optional BLINK_EN)
`timescale 1ns/1ps
module guess_game_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_250_000,
  parameter int unsigned REFRESH_DIV     = 125_000,
  parameter int unsigned MAX_TRIES       = 7,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input logic               clk,
  input logic               rst_n,
  guess_game_ctrl_if.slave  game_if
);

  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned     RF_W    = $clog2(REFRESH_DIV + 1);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_DIV - 1);
  localparam logic [3:0]      MAX_T   = 4'(MAX_TRIES);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CHECK, S_WIN, S_LOSE} state_t;

  // btn[0] = submit, btn[1] = new game; the upper two buttons are not wired to anything
  logic unused_btn;
  assign unused_btn = ^game_if.btn[3:2];

  logic [1:0]           sync1_q, sync2_q, stable_q, pulse_q;
  logic [1:0][DB_W-1:0] db_cnt_q;
  logic                 submit, new_game;

  assign submit   = pulse_q[0];
  assign new_game = pulse_q[1];

  // Synchronise each button, accept a new level after DEBOUNCE_CYCLES differing samples, pulse on accepted rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      pulse_q  <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= game_if.btn[1:0];
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        pulse_q[i] <= 1'b0;
        if (sync2_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_cnt_q[i] <= '0;
          stable_q[i] <= sync2_q[i];
          pulse_q[i]  <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  logic [7:0] lfsr_q;

  // Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4); non-zero seed keeps it off the all-zero lockup
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  state_t     state_q, state_d;
  logic [3:0] secret_q, secret_d;
  logic [3:0] guess_q, guess_d;
  logic [3:0] tries_q, tries_d;
  logic [3:0] led_q, led_d;

  // Game state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      secret_q <= '0;
      guess_q  <= '0;
      tries_q  <= '0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      secret_q <= secret_d;
      guess_q  <= guess_d;
      tries_q  <= tries_d;
      led_q    <= led_d;
    end
  end

  // Next-state logic; new game has priority over everything, which also drops a coincident submit
  always_comb begin
    state_d  = state_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    tries_d  = tries_q;
    led_d    = led_q;
    if (new_game) begin
      state_d  = S_PLAY;
      secret_d = lfsr_q[3:0];
      guess_d  = '0;
      tries_d  = '0;
      led_d    = '0;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (submit) begin
            guess_d = game_if.sw;
            tries_d = tries_q + 4'd1;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (guess_q == secret_q) begin
            led_d   = 4'b1111;
            state_d = S_WIN;
          end else if (tries_q == MAX_T) begin
            led_d   = 4'b1000;
            state_d = S_LOSE;
          end else begin
            led_d   = (guess_q < secret_q) ? 4'b0001 : 4'b0010;
            state_d = S_PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  logic [RF_W-1:0] ref_cnt_q;
  logic            chip_sel_q;
  logic [3:0]      digit_val_q, digit_val_d;
  logic            digit_blank_q, digit_blank_d;

  // Content of the currently selected digit; chip_sel 0 = ones, 1 = tens
  always_comb begin
    digit_val_d   = '0;
    digit_blank_d = 1'b0;
    case (state_q)
      S_PLAY, S_CHECK: digit_val_d = chip_sel_q ? (MAX_T - tries_q) : game_if.sw;
      S_WIN:           digit_val_d = chip_sel_q ? tries_q : secret_q;
      S_LOSE:          digit_val_d = chip_sel_q ? 4'd0 : secret_q;
      default:         digit_blank_d = 1'b1;
    endcase
  end

  // Display multiplex: toggle the selected digit every REFRESH_DIV cycles, register the digit content
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q     <= '0;
      chip_sel_q    <= 1'b0;
      digit_val_q   <= '0;
      digit_blank_q <= 1'b1;
    end else begin
      if (ref_cnt_q == RF_LAST) begin
        ref_cnt_q  <= '0;
        chip_sel_q <= ~chip_sel_q;
      end else begin
        ref_cnt_q <= ref_cnt_q + RF_W'(1);
      end
      digit_val_q   <= digit_val_d;
      digit_blank_q <= digit_blank_d;
    end
  end

  assign game_if.chip_sel    = chip_sel_q;
  assign game_if.digit_val   = digit_val_q;
  assign game_if.digit_blank = digit_blank_q;

`ifdef BLINK_EN
  localparam int unsigned     BL_W    = $clog2(16 * REFRESH_DIV + 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(16 * REFRESH_DIV - 1);

  logic [BL_W-1:0] blink_cnt_q;
  logic            blink_off_q;

  // Blink phase in WIN: starts lit on entry, flips every 16 display periods, cleared outside WIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (state_q != S_WIN) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (blink_cnt_q == BL_LAST) begin
      blink_cnt_q <= '0;
      blink_off_q <= ~blink_off_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BL_W'(1);
    end
  end

  assign game_if.led = blink_off_q ? 4'b0000 : led_q;
`else
  assign game_if.led = led_q;
`endif

endmodule

// File: tb/tb_guess_game_ctrl.sv
// tb/tb_guess_game_ctrl.sv - self-checking bench for guess_game_ctrl with a game-rule reference model
`timescale 1ns/1ps
module tb_guess_game_ctrl;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int MT = 3;
  localparam int WIN_OFS = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  guess_game_ctrl_if gif();

  guess_game_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REFRESH_DIV(RD),
    .MAX_TRIES(MT),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .game_if(gif)
  );

  int total = 0;
  int bad = 0;

  // posedges since reset release; at a negedge it is the index of the next posedge
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // LFSR value in effect at posedge number n after reset
  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] r;
    r = 8'hA5;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    return r;
  endfunction

  // calibrated distance from press start to the edge that samples the secret
  int off = -1;
  bit cand [WIN_OFS];

  function automatic logic [3:0] predict(input int c0);
    return lfsr_at(c0 + off) & 8'h0F;
  endfunction

  // game-rule model: done 0 = playing, 1 = won, 2 = lost
  logic [3:0] m_s;
  int         m_tries;
  logic [3:0] m_led;
  int         m_done;

  task automatic model_new(input logic [3:0] s);
    m_s = s; m_tries = 0; m_led = 4'h0; m_done = 0;
  endtask

  task automatic model_guess(input logic [3:0] g);
    if (m_done == 0) begin
      m_tries++;
      if (g == m_s) begin m_led = 4'hF; m_done = 1; end
      else if (m_tries == MT) begin m_led = 4'h8; m_done = 2; end
      else m_led = (g < m_s) ? 4'h1 : 4'h2;
    end
  endtask

  function automatic logic [3:0] exp_tens();
    if (m_done == 0) return 4'(MT - m_tries);
    if (m_done == 1) return 4'(m_tries);
    return 4'h0;
  endfunction

  task automatic press(input logic [3:0] mask, input int hold, output int c0);
    @(negedge clk);
    gif.btn = mask;
    c0 = cyc;
    repeat (hold) @(negedge clk);
    gif.btn = 4'h0;
    repeat (14) @(negedge clk);
  endtask

  task automatic submit(input logic [3:0] g);
    int c0;
    gif.sw = g;
    press(4'b0001, 10, c0);
  endtask

  task automatic read_digit(input bit tens, output logic [3:0] v, output logic b);
    int run;
    run = 0;
    v = 4'hx;
    b = 1'bx;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (gif.chip_sel == tens) run++; else run = 0;
      if (run >= 3) begin
        v = gif.digit_val;
        b = gif.digit_blank;
        return;
      end
    end
    total++; bad++;
    $display("FAIL digit_wait: chip_sel stuck, want %0d", tens);
  endtask

  task automatic test_reset();
    int t [3];
    int k;
    logic prev;
    gif.btn = 4'h0; gif.sw = 4'h0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (gif.led !== 4'h0) begin bad++; $display("FAIL rst_led: got %h want 0", gif.led); end
    total++; if (gif.chip_sel !== 1'b0) begin bad++; $display("FAIL rst_chip_sel: got %b want 0", gif.chip_sel); end
    total++; if (gif.digit_blank !== 1'b1) begin bad++; $display("FAIL rst_blank: got %b want 1", gif.digit_blank); end
    total++; if (gif.digit_val !== 4'h0) begin bad++; $display("FAIL rst_digit_val: got %h want 0", gif.digit_val); end
    rst_n = 1'b1;
    k = 0;
    prev = gif.chip_sel;
    for (int i = 0; i < 60 && k < 3; i++) begin
      @(negedge clk);
      if (gif.chip_sel !== prev) begin t[k] = cyc; k++; prev = gif.chip_sel; end
    end
    total++;
    if (k < 3) begin bad++; $display("FAIL refresh_toggles: got %0d toggles want 3", k); end
    else begin
      if (t[0] != RD) begin bad++; $display("FAIL refresh_first: got %0d want %0d", t[0], RD); end
      total++; if (t[1] - t[0] != RD) begin bad++; $display("FAIL refresh_period1: got %0d want %0d", t[1] - t[0], RD); end
      total++; if (t[2] - t[1] != RD) begin bad++; $display("FAIL refresh_period2: got %0d want %0d", t[2] - t[1], RD); end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] v;
    logic b;
    int c0;
    @(negedge clk);
    gif.btn = 4'b0010;
    repeat (2) @(negedge clk);
    gif.btn = 4'h0;
    repeat (20) @(negedge clk);
    read_digit(1'b1, v, b);
    total++; if (b !== 1'b1) begin bad++; $display("FAIL glitch_idle_blank: got %b want 1", b); end
    press(4'b0010, 20, c0);
    read_digit(1'b1, v, b);
    total++; if (b !== 1'b0) begin bad++; $display("FAIL newgame_blank: got %b want 0", b); end
    total++; if (v !== 4'(MT)) begin bad++; $display("FAIL newgame_tens: got %h want %h", v, 4'(MT)); end
    total++; if (gif.led !== 4'h0) begin bad++; $display("FAIL newgame_led: got %h want 0", gif.led); end
  endtask

  task automatic test_lose_calibrate();
    logic [3:0] v, s, tens_v;
    logic b;
    logic [3:0] leds [3];
    int c0, n;
    for (int k = 0; k < WIN_OFS; k++) cand[k] = 1'b1;
    for (int game = 0; game < 6; game++) begin
      press(4'b0010, 10, c0);
      for (int g = 0; g < 3; g++) begin
        submit(4'(g));
        leds[g] = gif.led;
      end
      read_digit(1'b0, s, b);
      read_digit(1'b1, tens_v, b);
      model_new(s);
      for (int g = 0; g < 3; g++) begin
        model_guess(4'(g));
        total++;
        if (leds[g] !== m_led) begin bad++; $display("FAIL lose_led%0d: got %h want %h (secret %h)", g, leds[g], m_led, s); end
      end
      total++; if (tens_v !== exp_tens()) begin bad++; $display("FAIL end_tens: got %h want %h", tens_v, exp_tens()); end
      for (int k = 0; k < WIN_OFS; k++)
        if ((lfsr_at(c0 + k) & 8'h0F) != {4'h0, s}) cand[k] = 1'b0;
      n = 0;
      for (int k = 0; k < WIN_OFS; k++) if (cand[k]) begin n++; off = k; end
      if (n == 1 && game >= 1) break;
    end
    total++;
    if (n != 1) begin bad++; off = -1; $display("FAIL secret_calibration: got %0d candidates want 1", n); end
  endtask

  task automatic test_win();
    logic [3:0] s, v;
    logic b;
    int c0;
    bit ok;
    ok = 0;
    for (int a = 0; a < 8 && !ok; a++) begin
      press(4'b0010, 10, c0);
      s = predict(c0);
      ok = (s >= 4'd1 && s <= 4'd14);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL win_secret_range: got %h want 1..14", s); return; end
    model_new(s);
    submit(s - 4'd1);
    model_guess(s - 4'd1);
    total++; if (gif.led !== 4'h1) begin bad++; $display("FAIL win_low_led: got %h want 1", gif.led); end
    read_digit(1'b1, v, b);
    total++; if (v !== 4'd2) begin bad++; $display("FAIL win_low_tens: got %h want 2", v); end
    read_digit(1'b0, v, b);
    total++; if (v !== s - 4'd1) begin bad++; $display("FAIL play_ones_sw: got %h want %h", v, s - 4'd1); end
    submit(s + 4'd1);
    model_guess(s + 4'd1);
    total++; if (gif.led !== 4'h2) begin bad++; $display("FAIL win_high_led: got %h want 2", gif.led); end
    read_digit(1'b1, v, b);
    total++; if (v !== 4'd1) begin bad++; $display("FAIL win_high_tens: got %h want 1", v); end
    submit(s);
    model_guess(s);
    total++; if (gif.led !== 4'hF) begin bad++; $display("FAIL win_led: got %h want F", gif.led); end
    read_digit(1'b1, v, b);
    total++; if (v !== 4'(MT)) begin bad++; $display("FAIL win_tens: got %h want %h", v, 4'(MT)); end
    submit(s - 4'd1);
    read_digit(1'b0, v, b);
    total++; if (v !== s) begin bad++; $display("FAIL win_ignore_ones: got %h want %h", v, s); end
    read_digit(1'b1, v, b);
    total++; if (v !== 4'(MT)) begin bad++; $display("FAIL win_ignore_tens: got %h want %h", v, 4'(MT)); end
  endtask

  task automatic test_random_games();
    logic [3:0] g, v;
    logic b;
    int c0;
    for (int game = 0; game < 3; game++) begin
      press(4'b0010, 10, c0);
      model_new(predict(c0));
      for (int t = 0; t < MT + 1; t++) begin
        g = 4'($urandom_range(0, 15));
        submit(g);
        model_guess(g);
        total++;
        if (gif.led !== m_led) begin bad++; $display("FAIL rand_led g%0d t%0d: got %h want %h", game, t, gif.led, m_led); end
      end
      read_digit(1'b1, v, b);
      total++; if (v !== exp_tens()) begin bad++; $display("FAIL rand_tens g%0d: got %h want %h", game, v, exp_tens()); end
      read_digit(1'b0, v, b);
      total++; if (v !== m_s) begin bad++; $display("FAIL rand_ones g%0d: got %h want %h", game, v, m_s); end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] s, v;
    logic b;
    int c0;
    press(4'b0010, 10, c0);
    s = predict(c0);
    submit(s ^ 4'h8);
    total++; if (gif.led !== ((s ^ 4'h8) < s ? 4'h1 : 4'h2)) begin bad++; $display("FAIL simul_pre_led: got %h", gif.led); end
    gif.sw = s;
    press(4'b0011, 10, c0);
    s = predict(c0);
    total++; if (gif.led !== 4'h0) begin bad++; $display("FAIL simul_led: got %h want 0", gif.led); end
    read_digit(1'b1, v, b);
    total++; if (v !== 4'(MT)) begin bad++; $display("FAIL simul_tens: got %h want %h", v, 4'(MT)); end
    submit(s);
    total++; if (gif.led !== 4'hF) begin bad++; $display("FAIL simul_win_led: got %h want F", gif.led); end
    read_digit(1'b1, v, b);
    total++; if (v !== 4'd1) begin bad++; $display("FAIL simul_win_tens: got %h want 1", v); end
    read_digit(1'b0, v, b);
    total++; if (v !== s) begin bad++; $display("FAIL simul_win_ones: got %h want %h", v, s); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] s, v;
    logic b;
    int c0;
    press(4'b0010, 10, c0);
    s = predict(c0);
    submit(s ^ 4'h4);
    total++; if (gif.led === 4'h0) begin bad++; $display("FAIL mid_pre_led: got %h want nonzero", gif.led); end
    gif.sw = s ^ 4'h2;
    @(negedge clk);
    gif.btn = 4'b0001;
    c0 = cyc;
    for (int i = 0; i < 40 && cyc < c0 + off + 1; i++) @(negedge clk);
    rst_n = 1'b0;
    gif.btn = 4'h0;
    #1;
    total++; if (gif.led !== 4'h0) begin bad++; $display("FAIL mid_rst_led: got %h want 0", gif.led); end
    total++; if (gif.digit_blank !== 1'b1) begin bad++; $display("FAIL mid_rst_blank: got %b want 1", gif.digit_blank); end
    total++; if (gif.chip_sel !== 1'b0) begin bad++; $display("FAIL mid_rst_chip_sel: got %b want 0", gif.chip_sel); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (gif.led !== 4'h0) begin bad++; $display("FAIL post_rst_led: got %h want 0", gif.led); end
    read_digit(1'b1, v, b);
    total++; if (b !== 1'b1) begin bad++; $display("FAIL post_rst_tens_blank: got %b want 1", b); end
    read_digit(1'b0, v, b);
    total++; if (b !== 1'b1) begin bad++; $display("FAIL post_rst_ones_blank: got %b want 1", b); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    gif.btn = 4'h0;
    gif.sw = 4'h0;
    test_reset();
    test_glitch();
    test_lose_calibrate();
    test_win();
    test_random_games();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
